// File: rtl/exu_mdu_pkg.sv
// rtl/exu_mdu_pkg.sv - shared encodings, state enum and constants for the multiply/divide unit
package exu_mdu_pkg;

    localparam int ARGS_WIDTH    = 4;
    localparam int MDU_MAX_WIDTH = 128;

    // Encodings 8..15 are unused and complete immediately with a zero result.
    typedef enum logic [ARGS_WIDTH-1:0] {
        MDU_MUL    = 4'd0,
        MDU_MULH   = 4'd1,
        MDU_MULHSU = 4'd2,
        MDU_MULHU  = 4'd3,
        MDU_DIV    = 4'd4,
        MDU_DIVU   = 4'd5,
        MDU_REM    = 4'd6,
        MDU_REMU   = 4'd7
    } mdu_type_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    function automatic logic [MDU_MAX_WIDTH-1:0] mdu_most_neg(input int width);
        return MDU_MAX_WIDTH'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/exu_mdu_step.sv
// rtl/exu_mdu_step.sv - one radix-2 iteration: shift-add multiply or restoring divide on the accumulator
module exu_mdu_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      is_div,
    input  logic [2*DATA_WIDTH-1:0]   acc,
    input  logic [DATA_WIDTH-1:0]     operand,
    output logic [2*DATA_WIDTH-1:0]   acc_next
);

    localparam int W = DATA_WIDTH;

    logic [W:0] sum;
    logic [W:0] shifted_hi;
    logic [W:0] trial;

    // Partial remainder stays below the divisor, so bit W of the trial is a clean borrow.
    always_comb begin
        sum        = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : {(W+1){1'b0}});
        shifted_hi = {acc[2*W-1:W], acc[W-1]};
        trial      = shifted_hi - {1'b0, operand};
        if (is_div) begin
            if (!trial[W]) begin
                acc_next = {trial[W-1:0], acc[W-2:0], 1'b1};
            end else begin
                acc_next = {shifted_hi[W-1:0], acc[W-2:0], 1'b0};
            end
        end else begin
            acc_next = {sum, acc[W-1:1]};
        end
    end

endmodule

// File: rtl/exu_mdu.sv
// rtl/exu_mdu.sv - iterative RV M-extension multiply/divide unit (MDU_FAST_MUL_EN: single-cycle multiplies)
module exu_mdu
    import exu_mdu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    input  logic                  i_sys_valid,
    output logic                  o_sys_ready,
    input  logic [ARGS_WIDTH-1:0] i_idu_ctr_mdu_type,
    input  logic [DATA_WIDTH-1:0] i_idu_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_idu_rs2_data,
    output logic                  o_sys_valid,
    input  logic                  i_sys_ready,
    output logic [DATA_WIDTH-1:0] o_exu_mdu_res,
    output logic                  o_exu_mdu_busy
);

    localparam int W = DATA_WIDTH;
    localparam logic [MDU_MAX_WIDTH-1:0] MOST_NEG_FULL = mdu_most_neg(DATA_WIDTH);
    localparam logic [W-1:0]         MOST_NEG  = MOST_NEG_FULL[W-1:0];
    localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(DATA_WIDTH);

    mdu_state_e            state;
    logic [ARGS_WIDTH-1:0] op_q;
    logic                  neg_q;
    logic                  is_div_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [W-1:0]          operand_q;
    logic [2*W-1:0]        acc_q;
    logic [2*W-1:0]        acc_step;
    logic [W-1:0]          res_q;
    logic                  ready_q;
    logic                  valid_q;
    logic                  busy_q;

    logic                  s1;
    logic                  s2;
    logic [W-1:0]          abs1;
    logic [W-1:0]          abs2;
    logic [W-1:0]          mag_a;
    logic [W-1:0]          mag_b;
    logic                  req_neg;
    logic                  req_div;
    logic                  special;
    logic [W-1:0]          special_res;
    logic                  div_zero;
    logic                  div_ovf;

`ifdef MDU_FAST_MUL_EN
    logic [2*W-1:0]        a_ext;
    logic [2*W-1:0]        b_ext;
    logic [2*W-1:0]        fast_prod;
`endif

    // Operands are reduced to magnitudes; the sign is reapplied once at the end.
    always_comb begin
        s1          = i_idu_rs1_data[W-1];
        s2          = i_idu_rs2_data[W-1];
        abs1        = s1 ? -i_idu_rs1_data : i_idu_rs1_data;
        abs2        = s2 ? -i_idu_rs2_data : i_idu_rs2_data;
        div_zero    = (i_idu_rs2_data == '0);
        div_ovf     = (i_idu_rs1_data == MOST_NEG) && (i_idu_rs2_data == '1);
        mag_a       = i_idu_rs1_data;
        mag_b       = i_idu_rs2_data;
        req_neg     = 1'b0;
        req_div     = 1'b0;
        special     = 1'b0;
        special_res = '0;
        case (i_idu_ctr_mdu_type)
            MDU_MUL, MDU_MULHU: ;
            MDU_MULH: begin
                mag_a   = abs1;
                mag_b   = abs2;
                req_neg = s1 ^ s2;
            end
            MDU_MULHSU: begin
                mag_a   = abs1;
                req_neg = s1;
            end
            MDU_DIV: begin
                req_div = 1'b1;
                mag_a   = abs1;
                mag_b   = abs2;
                req_neg = s1 ^ s2;
                if (div_zero) begin
                    special     = 1'b1;
                    special_res = '1;
                end else if (div_ovf) begin
                    special     = 1'b1;
                    special_res = MOST_NEG;
                end
            end
            MDU_DIVU: begin
                req_div = 1'b1;
                if (div_zero) begin
                    special     = 1'b1;
                    special_res = '1;
                end
            end
            MDU_REM: begin
                req_div = 1'b1;
                mag_a   = abs1;
                mag_b   = abs2;
                req_neg = s1;
                if (div_zero) begin
                    special     = 1'b1;
                    special_res = i_idu_rs1_data;
                end else if (div_ovf) begin
                    special     = 1'b1;
                    special_res = '0;
                end
            end
            MDU_REMU: begin
                req_div = 1'b1;
                if (div_zero) begin
                    special     = 1'b1;
                    special_res = i_idu_rs1_data;
                end
            end
            default: special = 1'b1;
        endcase
`ifdef MDU_FAST_MUL_EN
        // Sign/zero-extending to 2W makes the truncated product exact for every signedness.
        a_ext     = {{W{s1 && (i_idu_ctr_mdu_type == MDU_MULH || i_idu_ctr_mdu_type == MDU_MULHSU)}},
                     i_idu_rs1_data};
        b_ext     = {{W{s2 && (i_idu_ctr_mdu_type == MDU_MULH)}}, i_idu_rs2_data};
        fast_prod = a_ext * b_ext;
        if (i_idu_ctr_mdu_type == MDU_MUL) begin
            special     = 1'b1;
            special_res = fast_prod[W-1:0];
        end else if (i_idu_ctr_mdu_type == MDU_MULH || i_idu_ctr_mdu_type == MDU_MULHSU ||
                     i_idu_ctr_mdu_type == MDU_MULHU) begin
            special     = 1'b1;
            special_res = fast_prod[2*W-1:W];
        end
`endif
    end

    exu_mdu_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .is_div   (is_div_q),
        .acc      (acc_q),
        .operand  (operand_q),
        .acc_next (acc_step)
    );

    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   div_sel;
    logic [W-1:0]   calc_res;

    always_comb begin
        prod_fix = neg_q ? -acc_step : acc_step;
        div_sel  = (op_q == MDU_REM || op_q == MDU_REMU) ? acc_step[2*W-1:W] : acc_step[W-1:0];
        if (is_div_q) begin
            calc_res = neg_q ? -div_sel : div_sel;
        end else if (op_q == MDU_MUL) begin
            calc_res = prod_fix[W-1:0];
        end else begin
            calc_res = prod_fix[2*W-1:W];
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state     <= MDU_IDLE;
            op_q      <= '0;
            neg_q     <= 1'b0;
            is_div_q  <= 1'b0;
            cnt_q     <= '0;
            operand_q <= '0;
            acc_q     <= '0;
            res_q     <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                MDU_IDLE: begin
                    if (i_sys_valid && ready_q) begin
                        op_q      <= i_idu_ctr_mdu_type;
                        neg_q     <= req_neg;
                        is_div_q  <= req_div;
                        cnt_q     <= '0;
                        operand_q <= req_div ? mag_b : mag_a;
                        acc_q     <= {{W{1'b0}}, (req_div ? mag_a : mag_b)};
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        if (special) begin
                            res_q   <= special_res;
                            valid_q <= 1'b1;
                            state   <= MDU_DONE;
                        end else begin
                            state   <= MDU_CALC;
                        end
                    end
                end
                MDU_CALC: begin
                    acc_q <= acc_step;
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (cnt_q == LAST_STEP) begin
                        res_q   <= calc_res;
                        valid_q <= 1'b1;
                        state   <= MDU_DONE;
                    end
                end
                MDU_DONE: begin
                    if (i_sys_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= MDU_IDLE;
                    end
                end
                default: state <= MDU_IDLE;
            endcase
        end
    end

    assign o_sys_ready    = ready_q;
    assign o_sys_valid    = valid_q;
    assign o_exu_mdu_busy = busy_q;
    assign o_exu_mdu_res  = res_q;

endmodule

// File: tb/tb_exu_mdu.sv
// tb/tb_exu_mdu.sv - directed self-checking bench for exu_mdu at DATA_WIDTH = 32
module tb_exu_mdu;
    import exu_mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = 32;
`endif
    localparam int DIV_LAT = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  out_ready;
    logic [ARGS_WIDTH-1:0] op;
    logic [31:0]           rs1;
    logic [31:0]           rs2;
    logic                  out_valid;
    logic                  in_ready;
    logic [31:0]           res;
    logic                  busy;

    int checks   = 0;
    int failures = 0;

    exu_mdu #(
        .DATA_WIDTH (32)
    ) dut (
        .i_sys_clk          (clk),
        .i_sys_rst          (rst),
        .i_sys_valid        (in_valid),
        .o_sys_ready        (out_ready),
        .i_idu_ctr_mdu_type (op),
        .i_idu_rs1_data     (rs1),
        .i_idu_rs2_data     (rs2),
        .o_sys_valid        (out_valid),
        .i_sys_ready        (in_ready),
        .o_exu_mdu_res      (res),
        .o_exu_mdu_busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [ARGS_WIDTH-1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        op       = o;
        rs1      = a;
        rs2      = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat, output int hs_bad);
        lat    = 0;
        hs_bad = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (out_ready !== 1'b0 || busy !== 1'b1) hs_bad++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [ARGS_WIDTH-1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        int hs_bad;
        check({tag, ".ready_before"}, 32'(out_ready), 32'd1);
        issue(o, a, b);
        wait_valid(lat, hs_bad);
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".res"}, res, exp_res);
        check({tag, ".calc_handshake"}, hs_bad, 0);
        check({tag, ".done_busy"}, 32'(busy), 32'd1);
        in_ready = 1'b1;
        @(posedge clk);
        #1;
        in_ready = 1'b0;
        check({tag, ".after_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".after_ready"}, 32'(out_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int hs_bad;
        int unstable;
        int spurious;
        logic [31:0] held;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_ready = 1'b0;
        op       = '0;
        rs1      = '0;
        rs2      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.ready", 32'(out_ready), 32'd1);
        check("reset.valid", 32'(out_valid), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.res", res, 32'd0);
        rst = 1'b0;

        run("mul_7_m3", MDU_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run("mulhu_m1", MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run("mulh_m1", MDU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
        run("mulhsu_m1", MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        run("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT);
        run("rem_m7_2", MDU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT);
        run("divu_m7_2", MDU_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, DIV_LAT);
        run("remu_100_7", MDU_REMU, 32'd100, 32'd7, 32'd2, DIV_LAT);
        run("divu_by0", MDU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        run("remu_by0", MDU_REMU, 32'd5, 32'd0, 32'd5, 0);
        run("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run("rem_ovf", MDU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
        run("unknown_op", 4'd9, 32'd5, 32'd3, 32'd0, 0);

        // Backpressure with a competing request held in DONE
        issue(MDU_DIVU, 32'd100, 32'd3);
        wait_valid(lat, hs_bad);
        check("bp.latency", lat, DIV_LAT);
        check("bp.res", res, 32'd33);
        held     = res;
        unstable = 0;
        @(negedge clk);
        in_valid = 1'b1;
        op       = MDU_MUL;
        rs1      = 32'd9;
        rs2      = 32'd9;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || res !== held || out_ready !== 1'b0) unstable++;
        end
        check("bp.stable", unstable, 0);
        in_ready = 1'b1;
        @(posedge clk);
        #1;
        in_ready = 1'b0;
        check("bp.handoff_valid", 32'(out_valid), 32'd0);
        check("bp.no_reaccept_ready", 32'(out_ready), 32'd1);
        check("bp.no_reaccept_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;

        // Reset mid-divide discards the operation
        issue(MDU_DIV, 32'd1000, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        check("rst.mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.ready", 32'(out_ready), 32'd1);
        check("rst.busy", 32'(busy), 32'd0);
        spurious = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) spurious++;
        end
        check("rst.no_valid", spurious, 0);
        run("mul_3_4", MDU_MUL, 32'd3, 32'd4, 32'd12, MUL_LAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
